// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI read arbiter: AR/R payload structs and the FSM state encoding.
package axi_arb_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RESP_W  = 2;
  localparam int unsigned ID_W    = 4;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } ar_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RESP_W-1:0] resp;
    logic              last;
  } r_t;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arb_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping mod N_MST.
module rr_pick
  import axi_arb_pkg::*;
#(
  parameter int unsigned N_MST = 2,
  localparam int unsigned IDX_W = idx_width(N_MST)
) (
  input  logic [N_MST-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_MST-1:0] o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    int unsigned v_k;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    v_k   = 0;
    for (int unsigned off = 0; off < N_MST; off++) begin
      v_k = (32'(i_ptr) + off) % N_MST;
      if (!o_any && i_req[v_k]) begin
        o_gnt[v_k] = 1'b1;
        o_idx      = IDX_W'(v_k);
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin AXI4 read-port arbiter, one whole transaction (AR + full R burst) per grant.
// Optional ARB_PERF_EN adds saturating grant/wait/busy counters readable via hierarchy.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned N_MST = 2,
  parameter int unsigned AR_W  = $bits(ar_t),
  parameter int unsigned R_W   = $bits(r_t)
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [N_MST-1:0]        i_m_arvalid,
  output logic [N_MST-1:0]        o_m_arready,
  input  logic [N_MST*AR_W-1:0]   i_m_ar,
  output logic [N_MST-1:0]        o_m_rvalid,
  input  logic [N_MST-1:0]        i_m_rready,
  output logic [R_W-1:0]          o_m_r,
  output logic                    o_s_arvalid,
  input  logic                    i_s_arready,
  output logic [AR_W-1:0]         o_s_ar,
  output logic [ID_W-1:0]         o_s_arid,
  input  logic                    i_s_rvalid,
  output logic                    o_s_rready,
  input  logic [R_W-1:0]          i_s_r
);

  localparam int unsigned IDX_W = idx_width(N_MST);

  arb_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr, r_grant, w_idx, w_ptr_nxt;
  logic [N_MST-1:0] w_gnt;
  logic             w_any, w_capture, w_beat, w_last;
  logic [AR_W-1:0]  r_ar, w_ar_sel;

  rr_pick #(.N_MST(N_MST)) u_pick (
    .i_req (i_m_arvalid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_capture = (r_state == IDLE) && w_any && !i_reset;
  assign w_last    = i_s_r[0];
  assign w_beat    = (r_state == DATA) && i_s_rvalid && i_m_rready[r_grant];
  assign w_ptr_nxt = (w_idx == IDX_W'(N_MST - 1)) ? '0 : w_idx + 1'b1;

  always_comb begin
    w_ar_sel = '0;
    for (int unsigned k = 0; k < N_MST; k++) begin
      if (w_gnt[k]) w_ar_sel = i_m_ar[k*AR_W +: AR_W];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = ADDR;
      ADDR:    if (i_s_arready) w_state_nxt = DATA;
      DATA:    if (w_beat && w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_ar    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_grant <= w_idx;
        r_ar    <= w_ar_sel;
        r_ptr   <= w_ptr_nxt;
      end
    end
  end

  // R channel is a pure pass-through gated to the granted master while in DATA.
  always_comb begin
    o_m_arready = w_capture ? w_gnt : '0;
    o_m_rvalid  = '0;
    o_s_rready  = 1'b0;
    o_m_r       = '0;
    if (r_state == DATA) begin
      o_m_rvalid[r_grant] = i_s_rvalid;
      o_s_rready          = i_m_rready[r_grant];
      o_m_r               = i_s_r;
    end
  end

  assign o_s_arvalid = (r_state == ADDR);
  assign o_s_ar      = r_ar;
  assign o_s_arid    = ID_W'(r_grant);

`ifdef ARB_PERF_EN
  logic [31:0] r_perf_grants [N_MST];
  logic [31:0] r_perf_wait   [N_MST];
  logic [31:0] r_perf_busy;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int unsigned k = 0; k < N_MST; k++) begin
        r_perf_grants[k] <= '0;
        r_perf_wait[k]   <= '0;
      end
      r_perf_busy <= '0;
    end else begin
      for (int unsigned k = 0; k < N_MST; k++) begin
        if (o_m_arready[k] && (r_perf_grants[k] != '1))
          r_perf_grants[k] <= r_perf_grants[k] + 32'd1;
        if (i_m_arvalid[k] && !o_m_arready[k] && (r_perf_wait[k] != '1))
          r_perf_wait[k] <= r_perf_wait[k] + 32'd1;
      end
      if ((r_state != IDLE) && (r_perf_busy != '1))
        r_perf_busy <= r_perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter (2 masters, default payload widths).
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
  logic [89:0] m_ar;
  logic [34:0] m_r, s_r;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [44:0] s_ar;
  logic [3:0]  s_arid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.N_MST(2), .AR_W(45), .R_W(35)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_m_arvalid (m_arvalid),
    .o_m_arready (m_arready),
    .i_m_ar      (m_ar),
    .o_m_rvalid  (m_rvalid),
    .i_m_rready  (m_rready),
    .o_m_r       (m_r),
    .o_s_arvalid (s_arvalid),
    .i_s_arready (s_arready),
    .o_s_ar      (s_ar),
    .o_s_arid    (s_arid),
    .i_s_rvalid  (s_rvalid),
    .o_s_rready  (s_rready),
    .i_s_r       (s_r)
  );

  function automatic logic [44:0] mk_ar(input logic [31:0] addr, input logic [7:0] len);
    return {addr, len, 3'd2, 2'd1};
  endfunction

  function automatic logic [34:0] mk_r(input logic [31:0] data, input logic [1:0] resp, input logic last);
    return {data, resp, last};
  endfunction

  task automatic idle_inputs();
    m_arvalid = 2'b00; m_rready = 2'b00; s_arready = 1'b0;
    s_rvalid  = 1'b0;  s_r      = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); #1;
    checks++;
    if ({m_arready, m_rvalid, s_arvalid, s_rready} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000", {m_arready, m_rvalid, s_arvalid, s_rready});
    end
    checks++;
    if ({s_ar, s_arid, m_r} !== '0) begin
      errors++; $display("FAIL reset_data: got ar=%h id=%0d r=%h expected zeros", s_ar, s_arid, m_r);
    end
  endtask

  task automatic test_single();
    logic [44:0] a;
    a = mk_ar(32'h8000_0000, 8'd0);
    @(negedge clk);
    m_arvalid = 2'b01; m_ar[44:0] = a; #1;
    checks++;
    if (m_arready !== 2'b01 || s_arvalid !== 1'b0) begin
      errors++; $display("FAIL single_capture: got arready=%b s_arvalid=%b expected 01/0", m_arready, s_arvalid);
    end
    @(negedge clk);
    m_arvalid = 2'b00; s_arready = 1'b1; #1;
    checks++;
    if (s_arvalid !== 1'b1 || s_ar !== a || s_arid !== 4'd0 || m_arready !== 2'b00) begin
      errors++; $display("FAIL single_addr: got v=%b ar=%h id=%0d expected 1 %h 0", s_arvalid, s_ar, s_arid, a);
    end
    @(negedge clk);
    s_arready = 1'b0; s_rvalid = 1'b1; m_rready = 2'b01; s_r = mk_r(32'h1234_5678, 2'b00, 1'b1); #1;
    checks++;
    if (m_rvalid !== 2'b01 || m_r !== mk_r(32'h1234_5678, 2'b00, 1'b1) || s_rready !== 1'b1) begin
      errors++; $display("FAIL single_data: got rvalid=%b r=%h rready=%b", m_rvalid, m_r, s_rready);
    end
    @(negedge clk);
    m_rready = 2'b11; #1;
    checks++;
    if (s_rready !== 1'b0 || m_rvalid !== 2'b00 || s_arvalid !== 1'b0) begin
      errors++; $display("FAIL idle_ignores_r: got s_rready=%b rvalid=%b expected 0 00", s_rready, m_rvalid);
    end
    idle_inputs();
  endtask

  task automatic test_tie();
    logic [44:0] a0, a1;
    a0 = mk_ar(32'h0000_1000, 8'd0);
    a1 = mk_ar(32'h0000_2000, 8'd0);
    do_reset();
    @(negedge clk);
    m_arvalid = 2'b11; m_ar = {a1, a0}; #1;
    checks++;
    if (m_arready !== 2'b01) begin
      errors++; $display("FAIL tie_first: got arready=%b expected 01", m_arready);
    end
    @(negedge clk);
    m_arvalid = 2'b10; s_arready = 1'b1; #1;
    checks++;
    if (s_arid !== 4'd0 || s_ar !== a0 || m_arready !== 2'b00) begin
      errors++; $display("FAIL tie_addr0: got id=%0d ar=%h arready=%b expected 0 %h 00", s_arid, s_ar, m_arready, a0);
    end
    @(negedge clk);
    s_arready = 1'b0; s_rvalid = 1'b1; m_rready = 2'b11; s_r = mk_r(32'hA0, 2'b00, 1'b1); #1;
    checks++;
    if (m_rvalid !== 2'b01) begin
      errors++; $display("FAIL tie_rvalid0: got %b expected 01", m_rvalid);
    end
    @(negedge clk);
    s_rvalid = 1'b0; #1;
    checks++;
    if (m_arready !== 2'b10) begin
      errors++; $display("FAIL tie_second: got arready=%b expected 10", m_arready);
    end
    @(negedge clk);
    m_arvalid = 2'b00; s_arready = 1'b1; #1;
    checks++;
    if (s_arid !== 4'd1 || s_ar !== a1) begin
      errors++; $display("FAIL tie_addr1: got id=%0d ar=%h expected 1 %h", s_arid, s_ar, a1);
    end
    @(negedge clk);
    s_arready = 1'b0; s_rvalid = 1'b1; s_r = mk_r(32'hA1, 2'b00, 1'b1); #1;
    checks++;
    if (m_rvalid !== 2'b10 || m_r !== mk_r(32'hA1, 2'b00, 1'b1)) begin
      errors++; $display("FAIL tie_rvalid1: got rvalid=%b r=%h expected 10", m_rvalid, m_r);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_burst();
    int sent;
    bit done;
    sent = 0; done = 1'b0;
    @(negedge clk);
    m_arvalid = 2'b10; m_ar[89:45] = mk_ar(32'h0000_3000, 8'd3); #1;
    checks++;
    if (m_arready !== 2'b10) begin
      errors++; $display("FAIL burst_capture: got %b expected 10", m_arready);
    end
    @(negedge clk);
    m_arvalid = 2'b00; s_arready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      s_arready = 1'b0; s_rvalid = 1'b1;
      s_r = mk_r(32'hB0 + sent, 2'b00, sent == 3);
      m_rready = (c % 2 == 1) ? 2'b10 : 2'b00; #1;
      checks++;
      if (m_rvalid !== 2'b10 || s_rready !== m_rready[1]) begin
        errors++; $display("FAIL burst_hs: cycle %0d got rvalid=%b s_rready=%b", c, m_rvalid, s_rready);
      end
      if (m_rready[1]) begin
        checks++;
        if (m_r[34:3] !== 32'hB0 + sent) begin
          errors++; $display("FAIL burst_data: beat %0d got %h expected %h", sent, m_r[34:3], 32'hB0 + sent);
        end
        if (sent == 3) done = 1'b1;
        sent++;
      end
    end
    checks++;
    if (sent !== 4) begin
      errors++; $display("FAIL burst_count: got %0d beats expected 4", sent);
    end
    @(negedge clk);
    idle_inputs(); m_rready = 2'b10; s_rvalid = 1'b1; #1;
    checks++;
    if (m_rvalid !== 2'b00 || s_arvalid !== 1'b0) begin
      errors++; $display("FAIL burst_end: got rvalid=%b s_arvalid=%b expected 00 0", m_rvalid, s_arvalid);
    end
    idle_inputs();
  endtask

  task automatic test_blocking();
    @(negedge clk);
    m_arvalid = 2'b10; m_ar[89:45] = mk_ar(32'h0000_4000, 8'd1); #1;
    @(negedge clk);
    m_arvalid = 2'b00; s_arready = 1'b1;
    @(negedge clk);
    s_arready = 1'b0; s_rvalid = 1'b1; m_rready = 2'b10;
    m_arvalid = 2'b01; m_ar[44:0] = mk_ar(32'h0000_5000, 8'd0);
    s_r = mk_r(32'hC0, 2'b00, 1'b0); #1;
    checks++;
    if (m_arready !== 2'b00 || m_rvalid !== 2'b10) begin
      errors++; $display("FAIL block_beat0: got arready=%b rvalid=%b expected 00 10", m_arready, m_rvalid);
    end
    @(negedge clk);
    s_r = mk_r(32'hC1, 2'b00, 1'b1); #1;
    checks++;
    if (m_arready !== 2'b00) begin
      errors++; $display("FAIL block_last: got arready=%b expected 00", m_arready);
    end
    @(negedge clk);
    s_rvalid = 1'b0; #1;
    checks++;
    if (m_arready !== 2'b01) begin
      errors++; $display("FAIL block_after: got arready=%b expected 01", m_arready);
    end
    @(negedge clk);
    m_arvalid = 2'b00; s_arready = 1'b1; #1;
    checks++;
    if (s_arid !== 4'd0) begin
      errors++; $display("FAIL block_id: got %0d expected 0", s_arid);
    end
    @(negedge clk);
    s_arready = 1'b0; s_rvalid = 1'b1; m_rready = 2'b01; s_r = mk_r(32'hC2, 2'b00, 1'b1);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_error();
    @(negedge clk);
    m_arvalid = 2'b01; m_ar[44:0] = mk_ar(32'h0000_6000, 8'd1);
    @(negedge clk);
    m_arvalid = 2'b00; s_arready = 1'b1;
    @(negedge clk);
    s_arready = 1'b0; s_rvalid = 1'b1; m_rready = 2'b01; s_r = mk_r(32'hDEAD_0000, 2'b10, 1'b0); #1;
    checks++;
    if (m_r !== mk_r(32'hDEAD_0000, 2'b10, 1'b0) || m_rvalid !== 2'b01) begin
      errors++; $display("FAIL err_beat0: got r=%h rvalid=%b", m_r, m_rvalid);
    end
    @(negedge clk);
    s_r = mk_r(32'hDEAD_0001, 2'b10, 1'b1); #1;
    checks++;
    if (m_r !== mk_r(32'hDEAD_0001, 2'b10, 1'b1) || m_rvalid !== 2'b01) begin
      errors++; $display("FAIL err_last: got r=%h rvalid=%b expected still DATA", m_r, m_rvalid);
    end
    @(negedge clk);
    s_rvalid = 1'b0; m_arvalid = 2'b10; m_ar[89:45] = mk_ar(32'h0000_7000, 8'd3); #1;
    checks++;
    if (m_arready !== 2'b10) begin
      errors++; $display("FAIL err_next: got arready=%b expected 10", m_arready);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    m_arvalid = 2'b00; s_arready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      s_arready = 1'b0; s_rvalid = 1'b1; m_rready = 2'b10; s_r = mk_r(32'hE0 + b, 2'b00, 1'b0);
    end
    @(negedge clk);
    s_r = mk_r(32'hE2, 2'b00, 1'b0); rst = 1'b1; #1;
    checks++;
    if (m_rvalid !== 2'b10) begin
      errors++; $display("FAIL rstmid_beat2: got rvalid=%b expected 10", m_rvalid);
    end
    @(negedge clk);
    rst = 1'b0; #1;
    checks++;
    if ({m_arready, m_rvalid, s_arvalid, s_rready} !== 6'b0 || s_ar !== '0 || s_arid !== 4'd0 || m_r !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got ctl=%b ar=%h id=%0d r=%h expected zeros",
                         {m_arvalid, m_rvalid, s_arvalid, s_rready}, s_ar, s_arid, m_r);
    end
    checks++;
    if (dut.r_ptr !== 1'b0) begin
      errors++; $display("FAIL rstmid_ptr: got %0d expected 0", dut.r_ptr);
    end
    @(negedge clk);
    idle_inputs(); m_arvalid = 2'b11; #1;
    checks++;
    if (m_arready !== 2'b01) begin
      errors++; $display("FAIL rstmid_tie: got arready=%b expected 01", m_arready);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1; m_ar = '0;
    idle_inputs();
    test_reset();
    test_single();
    test_tie();
    test_burst();
    test_blocking();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
